candy_key_decoder: RTL

Input stage in front of the vending FSM inside `candy_top`. It takes the raw 6-bit push-key bus from the board and produces clean, single-cycle coin and button events:

- synchronises each key,
- debounces each key independently,
- detects presses,
- serialises simultaneous presses in a fixed priority order.

It replaces direct use of `key_in` by the controller, which consumes only `coin` and `btn`.

---
 rtl/candy_key_decoder_pkg.sv | 19 +
 rtl/candy_key_decoder_debounce.sv | 49 ++++
 rtl/candy_key_decoder.sv | 78 +++++++
 3 files changed

// File: rtl/candy_key_decoder_pkg.sv
// Shared key indices and event codes for the candy vending input path.
// Used by the key decoder and the vending FSM that consumes its events.
package candy_key_decoder_pkg;

  localparam int NKEYS       = 6;
  localparam int KEY_COIN100 = 5;
  localparam int KEY_COIN50  = 4;
  localparam int KEY_CANDY   = 3;
  localparam int KEY_REFUND  = 2;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;

  localparam logic [1:0] BTN_NONE   = 2'b00;
  localparam logic [1:0] BTN_CANDY  = 2'b01;
  localparam logic [1:0] BTN_REFUND = 2'b10;

endpackage

// File: rtl/candy_key_decoder_debounce.sv
// Single-key 2-flop synchroniser, debounce counter and debounced level.
// Ports: clk, reset (sync, active-high), key_i raw key, deb_o debounced level.
module candy_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic deb_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample equal to the current level restarts the count, so
  // only an unbroken run of differing samples flips the level.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= key_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/candy_key_decoder.sv
// Key input stage: per-key debounce, press detect, priority issue.
// Ports: clk, reset, key_in[5:0] raw; coin/btn one-cycle events; key_level.
module candy_key_decoder
  import candy_key_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_in,
  output logic [1:0]       coin,
  output logic [1:0]       btn,
  output logic [NKEYS-1:0] key_level
);

  logic [NKEYS-1:0] deb;
  logic [5:2]       deb_d_q;
  logic [5:2]       pend_q, pend_d;
  logic [5:2]       rise, grant;
  logic [1:0]       coin_q, coin_d;
  logic [1:0]       btn_q, btn_d;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    candy_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .key_i(key_in[k]),
      .deb_o(deb[k])
    );
  end

  assign rise = deb[5:2] & ~deb_d_q;

  always_comb begin
    grant  = '0;
    coin_d = COIN_NONE;
    btn_d  = BTN_NONE;
    if (pend_q[KEY_COIN100]) begin
      grant[KEY_COIN100] = 1'b1;
      coin_d = COIN_100;
    end else if (pend_q[KEY_COIN50]) begin
      grant[KEY_COIN50] = 1'b1;
      coin_d = COIN_50;
    end else if (pend_q[KEY_CANDY]) begin
      grant[KEY_CANDY] = 1'b1;
      btn_d = BTN_CANDY;
    end else if (pend_q[KEY_REFUND]) begin
      grant[KEY_REFUND] = 1'b1;
      btn_d = BTN_REFUND;
    end
  end

  // A press on an already pending key merges into the same flag.
  assign pend_d = (pend_q & ~grant) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_d_q <= '0;
      pend_q  <= '0;
      coin_q  <= COIN_NONE;
      btn_q   <= BTN_NONE;
    end else begin
      deb_d_q <= deb[5:2];
      pend_q  <= pend_d;
      coin_q  <= coin_d;
      btn_q   <= btn_d;
    end
  end

  assign coin      = coin_q;
  assign btn       = btn_q;
  assign key_level = deb;

endmodule
